obi_sram_bank_arbiter: RTL and testbench
========================================

// Module: obi_sram_bank_arbiter
// PURPOSE
//  Round-robin arbiter sharing one single-port SRAM bank between NumMgr OBI requesters.
//  Sits between the crossbar/bank fan-out and one SRAM macro; one instance per bank.
//  Grants at most one request per cycle and drives the macro directly.
//  Returns the OBI response (rvalid/rdata/rid/err) to the winner one cycle later.
// PARAMETERS
//  NumMgr        4   number of competing OBI requesters (>=1)
//  AddrWidth     32  OBI byte-address width
//  DataWidth     32  data width; BE width = DataWidth/8
//  IdWidth       3   OBI aid/rid width
//  BankAddrWidth 9   SRAM word-address width (512 words)
// PORTS
//  clk_i         in   1                  clock
//  rst_ni        in   1                  asynchronous reset, active-low
//  req_i         in   NumMgr             per-requester OBI req
//  we_i          in   NumMgr             per-requester write enable
//  addr_i        in   NumMgr*AddrWidth   per-requester byte address, slice i at [i*AddrWidth +: AddrWidth]
//  be_i          in   NumMgr*DataWidth/8 per-requester byte enables
//  wdata_i       in   NumMgr*DataWidth   per-requester write data
//  aid_i         in   NumMgr*IdWidth     per-requester transaction ID
//  gnt_o         out  NumMgr             one-hot grant (or all zero)
//  rvalid_o      out  NumMgr             one-hot response valid
//  rdata_o       out  DataWidth          response data, shared by all requesters
//  rid_o         out  IdWidth            response ID, shared by all requesters
//  err_o         out  1                  response error, shared by all requesters
//  sram_req_o    out  1                  macro access enable
//  sram_we_o     out  1                  macro write enable
//  sram_addr_o   out  BankAddrWidth      macro word address
//  sram_be_o     out  DataWidth/8        macro byte enables
//  sram_wdata_o  out  DataWidth          macro write data
//  sram_rdata_i  in   DataWidth          macro read data, valid 1 cycle after sram_req_o
// BEHAVIOUR
//  Reset
//   - RR pointer = 0.
//   - Response register cleared.
//   - All outputs 0.
//  Arbitration (combinational, same cycle)
//   - Winner = first requester with req_i set, searching from the pointer upward with wrap (NumMgr-1 -> 0).
//   - gnt_o[winner] = 1 in the same cycle as req_i. No grant if no req_i is set.
//   - gnt_o never depends on rvalid or on other state. The bank accepts one request every cycle.
//  Pointer
//   - On a grant, pointer <= (winner+1) mod NumMgr.
//   - No grant: pointer holds.
//  SRAM drive (same cycle as the grant)
//   - sram_req_o = |req_i.
//   - sram_we_o, sram_be_o and sram_wdata_o are taken from the winner.
//   - sram_addr_o = winner addr[BankAddrWidth+1:2]. Upper bits and the byte offset are ignored.
//   - When idle, all sram_* outputs are 0.
//  Response stage (one register)
//   - On a grant, capture {valid=1, idx=winner, we, aid}; otherwise valid <= 0.
//   - The next cycle: rvalid_o[idx] = valid, rid_o = aid, err_o = 0.
//   - rdata_o = sram_rdata_i for a read, 0 for a write.
//   - rid_o and rdata_o are 0 when valid = 0.
//  Latency and throughput
//   - Latency req->gnt is 0 cycles; gnt->rvalid is exactly 1 cycle.
//   - Back-to-back grants give back-to-back responses with no bubbles.
//  Simultaneous events
//   - All requesters asserted: grants rotate 0,1,2,3,0,... one per cycle.
//   - A requester may receive its rvalid and a new grant in the same cycle.
//  Reset mid-operation
//   - A pending response is discarded (no rvalid after reset release).
//   - The pointer returns to 0.
// TESTING
//  T1: single requester 2 writes 0xDEADBEEF, be=4'hF, addr 0x1000_0010
//      -> gnt same cycle, sram_addr=4, rvalid[2] next cycle, rdata=0.
//  T2: read back addr 0x1000_0010 with aid=5 from requester 1
//      -> rvalid[1] one cycle after gnt, rdata=0xDEADBEEF, rid=5.
//  T3: all 4 requesters hold req for 8 cycles from reset
//      -> gnt sequence 0,1,2,3,0,1,2,3 with exactly one gnt per cycle.
//  T4: requesters 1 and 3 request after a grant to 3
//      -> pointer=0, requester 1 wins, then requester 3 wins next cycle.
//  T5: byte write be=4'b0100 data 0x00AB0000 over 0xDEADBEEF, then read
//      -> rdata=0xDEABBEEF.
//  T6: assert rst_ni low in the cycle after a read grant
//      -> no rvalid after release, first post-reset grant goes to the lowest-index requester.

Source files
------------

// File: rtl/obi_sram_bank_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM bank between NumMgr OBI requesters.
// Grant and SRAM drive are combinational; the OBI response follows one cycle after the grant.
module obi_sram_bank_arbiter #(
  parameter int unsigned NumMgr        = 4,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned IdWidth       = 3,
  parameter int unsigned BankAddrWidth = 9
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumMgr-1:0]               req_i,
  input  logic [NumMgr-1:0]               we_i,
  input  logic [NumMgr*AddrWidth-1:0]     addr_i,
  input  logic [NumMgr*(DataWidth/8)-1:0] be_i,
  input  logic [NumMgr*DataWidth-1:0]     wdata_i,
  input  logic [NumMgr*IdWidth-1:0]       aid_i,
  output logic [NumMgr-1:0]               gnt_o,
  output logic [NumMgr-1:0]               rvalid_o,
  output logic [DataWidth-1:0]            rdata_o,
  output logic [IdWidth-1:0]              rid_o,
  output logic                            err_o,
  output logic                            sram_req_o,
  output logic                            sram_we_o,
  output logic [BankAddrWidth-1:0]        sram_addr_o,
  output logic [DataWidth/8-1:0]          sram_be_o,
  output logic [DataWidth-1:0]            sram_wdata_o,
  input  logic [DataWidth-1:0]            sram_rdata_i
);

  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int unsigned IdxW    = (NumMgr > 1) ? $clog2(NumMgr) : 1;

  logic [IdxW-1:0]    ptr_q;
  logic [IdxW-1:0]    win_idx;
  logic               win_vld;
  logic [NumMgr-1:0]  req_eff;
  logic [IdWidth-1:0] win_aid;

  logic               rsp_vld_p1;
  logic [IdxW-1:0]    rsp_idx_p1;
  logic               rsp_we_p1;
  logic [IdWidth-1:0] rsp_aid_p1;

  // Outputs are forced quiet while reset is held.
  assign req_eff = req_i & {NumMgr{rst_ni}};

  // Stage p0: first requester at or above the pointer wins, else the lowest one (wrap).
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int j = 0; j < NumMgr; j++) begin
      if (!win_vld && req_eff[j] && (IdxW'(j) >= ptr_q)) begin
        win_vld = 1'b1;
        win_idx = IdxW'(j);
      end
    end
    for (int j = 0; j < NumMgr; j++) begin
      if (!win_vld && req_eff[j]) begin
        win_vld = 1'b1;
        win_idx = IdxW'(j);
      end
    end
  end

  always_comb begin
    gnt_o        = '0;
    sram_req_o   = win_vld;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_be_o    = '0;
    sram_wdata_o = '0;
    win_aid      = '0;
    for (int j = 0; j < NumMgr; j++) begin
      if (win_vld && (win_idx == IdxW'(j))) begin
        gnt_o[j]     = 1'b1;
        sram_we_o    = we_i[j];
        sram_addr_o  = addr_i[j*AddrWidth+2 +: BankAddrWidth];
        sram_be_o    = be_i[j*BeWidth +: BeWidth];
        sram_wdata_o = wdata_i[j*DataWidth +: DataWidth];
        win_aid      = aid_i[j*IdWidth +: IdWidth];
      end
    end
  end

  // Stage p1: pointer update and response capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      rsp_vld_p1 <= 1'b0;
      rsp_idx_p1 <= '0;
      rsp_we_p1  <= 1'b0;
      rsp_aid_p1 <= '0;
    end else begin
      rsp_vld_p1 <= win_vld;
      if (win_vld) begin
        ptr_q      <= (win_idx == IdxW'(NumMgr - 1)) ? '0 : win_idx + 1'b1;
        rsp_idx_p1 <= win_idx;
        rsp_we_p1  <= sram_we_o;
        rsp_aid_p1 <= win_aid;
      end
    end
  end

  always_comb begin
    rvalid_o = '0;
    for (int j = 0; j < NumMgr; j++) begin
      if (rsp_vld_p1 && (rsp_idx_p1 == IdxW'(j))) rvalid_o[j] = 1'b1;
    end
  end

  assign rdata_o = (rsp_vld_p1 && !rsp_we_p1) ? sram_rdata_i : '0;
  assign rid_o   = rsp_vld_p1 ? rsp_aid_p1 : '0;
  assign err_o   = 1'b0;

endmodule

// File: tb/tb_obi_sram_bank_arbiter.sv
// Scoreboard bench for obi_sram_bank_arbiter: directed scenarios then randomized traffic
// against a round-robin/memory reference model; a monitor pops expectations each cycle.
module tb_obi_sram_bank_arbiter;

  localparam int NM = 4;

  logic          clk;
  logic          rst_ni;
  logic [3:0]    req, we;
  logic [127:0]  addr;
  logic [15:0]   be;
  logic [127:0]  wdata;
  logic [11:0]   aid;
  logic [3:0]    gnt, rvalid;
  logic [31:0]   rdata;
  logic [2:0]    rid;
  logic          err;
  logic          sram_req, sram_we;
  logic [8:0]    sram_addr;
  logic [3:0]    sram_be;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  obi_sram_bank_arbiter #(
    .NumMgr(4), .AddrWidth(32), .DataWidth(32), .IdWidth(3), .BankAddrWidth(9)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
    .wdata_i(wdata), .aid_i(aid), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .rid_o(rid), .err_o(err), .sram_req_o(sram_req), .sram_we_o(sram_we),
    .sram_addr_o(sram_addr), .sram_be_o(sram_be), .sram_wdata_o(sram_wdata),
    .sram_rdata_i(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro model driven purely by the DUT's sram_* pins.
  logic [31:0] mem [512];
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  typedef struct {
    longint      t;
    logic [3:0]  gnt;
    logic        sreq;
    logic        swe;
    logic [8:0]  saddr;
    logic [3:0]  sbe;
    logic [31:0] swd;
  } gexp_t;

  typedef struct {
    longint      t;
    logic [3:0]  rv;
    logic [31:0] rd;
    logic [2:0]  rid;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  int checks = 0;
  int errors = 0;

  // Reference state: round-robin pointer and memory image by word index.
  int          rr = 0;
  bit   [31:0] ref_mem [512];

  logic        st_we   [4];
  logic [31:0] st_addr [4];
  logic [3:0]  st_be   [4];
  logic [31:0] st_wd   [4];
  logic [2:0]  st_aid  [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_mgr(input int i, input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input logic [2:0] id);
    st_we[i] = w; st_addr[i] = a; st_be[i] = b; st_wd[i] = d; st_aid[i] = id;
  endtask

  task automatic step(input logic [3:0] r);
    gexp_t  g;
    rexp_t  e;
    int     w;
    int     word;
    longint tnow;
    @(negedge clk);
    tnow   = longint'($time);
    rst_ni = 1'b1;
    req    = r;
    for (int i = 0; i < NM; i++) begin
      we[i]             = st_we[i];
      addr[i*32 +: 32]  = st_addr[i];
      be[i*4 +: 4]      = st_be[i];
      wdata[i*32 +: 32] = st_wd[i];
      aid[i*3 +: 3]     = st_aid[i];
    end
    w = -1;
    for (int k = 0; k < NM; k++) begin
      int c;
      c = (rr + k) % NM;
      if (w < 0 && r[c]) w = c;
    end
    g = '{tnow, 4'h0, 1'b0, 1'b0, 9'h0, 4'h0, 32'h0};
    if (w >= 0) begin
      word = int'(st_addr[w] >> 2) % 512;
      g.gnt = 4'(1 << w); g.sreq = 1'b1; g.swe = st_we[w];
      g.saddr = 9'(word); g.sbe = st_be[w]; g.swd = st_wd[w];
      e.t = tnow + 10; e.rv = 4'(1 << w); e.rid = st_aid[w];
      e.rd = st_we[w] ? 32'h0 : ref_mem[word];
      rq.push_back(e);
      if (st_we[w])
        for (int b = 0; b < 4; b++)
          if (st_be[w][b]) ref_mem[word][8*b +: 8] = st_wd[w][8*b +: 8];
      rr = (w + 1) % NM;
    end
    gq.push_back(g);
  endtask

  task automatic reset_cycles(input int n);
    longint tnow;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      tnow   = longint'($time);
      rst_ni = 1'b0;
      req    = 4'h0;
      rr     = 0;
      while (rq.size() > 0 && rq[rq.size()-1].t >= tnow) void'(rq.pop_back());
      gq.push_back('{tnow, 4'h0, 1'b0, 1'b0, 9'h0, 4'h0, 32'h0});
    end
  endtask

  // Monitor: sample 1 ns before each rising edge.
  initial begin
    gexp_t  g;
    rexp_t  e;
    longint tnow;
    forever begin
      @(negedge clk);
      #4;
      tnow = longint'($time) - 4;
      if (gq.size() > 0 && gq[0].t == tnow) begin
        g = gq.pop_front();
        chk("gnt", 64'(gnt), 64'(g.gnt));
        chk("sram_req", 64'(sram_req), 64'(g.sreq));
        if (g.sreq) begin
          chk("sram_we", 64'(sram_we), 64'(g.swe));
          chk("sram_addr", 64'(sram_addr), 64'(g.saddr));
          chk("sram_be", 64'(sram_be), 64'(g.sbe));
          chk("sram_wdata", 64'(sram_wdata), 64'(g.swd));
        end else begin
          chk("sram_idle", {sram_we, sram_addr, sram_be, sram_wdata}, 64'h0);
        end
        if (rq.size() > 0 && rq[0].t == tnow) begin
          e = rq.pop_front();
          chk("rvalid", 64'(rvalid), 64'(e.rv));
          chk("rdata", 64'(rdata), 64'(e.rd));
          chk("rid", 64'(rid), 64'(e.rid));
          chk("err", 64'(err), 64'h0);
        end else begin
          chk("rsp_idle", {rvalid, rid, rdata, err}, 64'h0);
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    req = '0; we = '0; addr = '0; be = '0; wdata = '0; aid = '0;
    for (int i = 0; i < NM; i++) set_mgr(i, 1'b0, 32'h0, 4'h0, 32'h0, 3'h0);
    reset_cycles(3);

    // T1: requester 2 writes, then T2: requester 1 reads it back with aid 5.
    set_mgr(2, 1'b1, 32'h1000_0010, 4'hF, 32'hDEAD_BEEF, 3'd2);
    step(4'b0100);
    set_mgr(1, 1'b0, 32'h1000_0010, 4'hF, 32'h0, 3'd5);
    step(4'b0010);
    // T5: byte-lane write then read back.
    set_mgr(0, 1'b1, 32'h1000_0010, 4'b0100, 32'h00AB_0000, 3'd1);
    step(4'b0001);
    set_mgr(3, 1'b0, 32'h2000_0013, 4'h0, 32'h0, 3'd7);
    step(4'b1000);
    step(4'b0000);

    // T3: all requesters reading from reset, rotation 0,1,2,3,...
    reset_cycles(2);
    for (int i = 0; i < NM; i++) set_mgr(i, 1'b0, 32'h0000_0010 + (i << 12), 4'hF, 32'h0, 3'(i));
    for (int c = 0; c < 8; c++) step(4'hF);

    // T4: grant to 3 alone, then 1 and 3 together.
    step(4'b1000);
    step(4'b1010);
    step(4'b1010);
    step(4'b0000);

    // Prefill words 0..7 for the random phase.
    for (int wd = 0; wd < 8; wd++) begin
      set_mgr(0, 1'b1, 32'(wd << 2), 4'hF, $urandom, 3'd0);
      step(4'b0001);
    end

    // T6: read grant, reset in the following cycle, then 2 and 3 compete.
    set_mgr(1, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 3'd6);
    step(4'b0010);
    reset_cycles(2);
    set_mgr(2, 1'b0, 32'h0000_0004, 4'hF, 32'h0, 3'd2);
    set_mgr(3, 1'b0, 32'h0000_0008, 4'hF, 32'h0, 3'd3);
    step(4'b1100);
    step(4'b1100);

    // Randomized traffic with one mid-stream reset.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NM; i++)
        set_mgr(i, 1'($urandom), ($urandom & 32'hFFFF_F800) | 32'(($urandom % 8) << 2) | 32'($urandom % 4),
                4'($urandom), $urandom, 3'($urandom));
      if (c == 150) reset_cycles(2);
      step(($urandom % 4 == 0) ? 4'hF : 4'($urandom));
    end

    for (int c = 0; c < 3; c++) step(4'h0);
    @(negedge clk);
    #6;
    chk("rsp_queue_drained", 64'(rq.size()), 64'h0);
    chk("gnt_queue_drained", 64'(gq.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
